// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: mfc0/mtc0/syscall/eret responder for the writeback stage,
// plus the Count/Compare timer and the interrupt-pending summary for the front end.
module cp0_regfile #(
  parameter logic [31:0] EX_ENTRY   = 32'hBFC0_0380,
  parameter bit          COUNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  c0_exception,
  input  logic [4:0]  c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic        c0_wb_valid,
  input  logic        c0_wb_bd,
  input  logic [31:0] c0_wb_pc,
  input  logic [5:0]  ext_int,
  output logic        c0_valid,
  output logic [31:0] c0_res,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        int_req
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;

  logic [31:0] status;
  logic [31:0] cause;
  logic        do_sys, do_eret, do_mtc0, do_mfc0;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // c0_exception = {sys, mfc0, mtc0, eret}; priority sys > eret > mtc0 > mfc0
  assign do_sys  = c0_wb_valid & c0_exception[3];
  assign do_eret = c0_wb_valid & c0_exception[0] & ~c0_exception[3];
  assign do_mtc0 = c0_wb_valid & c0_exception[1] & ~c0_exception[3] & ~c0_exception[0];
  assign do_mfc0 = c0_wb_valid & c0_exception[2] & ~c0_exception[3] & ~c0_exception[1]
                   & ~c0_exception[0];

  assign wr_count   = do_mtc0 && (c0_addr == 5'd9);
  assign wr_compare = do_mtc0 && (c0_addr == 5'd11);
  assign wr_status  = do_mtc0 && (c0_addr == 5'd12);
  assign wr_cause   = do_mtc0 && (c0_addr == 5'd13);
  assign wr_epc     = do_mtc0 && (c0_addr == 5'd14);

  assign status = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b0};

  always_comb begin
    c0_res = '0;
    case (c0_addr)
      5'd9:    c0_res = count;
      5'd11:   c0_res = compare;
      5'd12:   c0_res = status;
      5'd13:   c0_res = cause;
      5'd14:   c0_res = epc;
      default: c0_res = '0;
    endcase
  end

  assign c0_valid = do_mfc0;
  assign flush    = do_sys | do_eret;
  assign flush_pc = do_sys ? EX_ENTRY : epc;
  assign int_req  = status_ie & ~status_exl & (|({cause_ip_hw, cause_ip_sw} & status_im));

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ti    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      epc         <= '0;
      count       <= '0;
      compare     <= '0;
      tick        <= 1'b0;
    end else begin
      tick <= COUNT_DIV2 ? ~tick : 1'b1;

      if (wr_count)
        count <= c0_wdata;
      else if (tick)
        count <= count + 32'd1;

      // a Compare write clears TI even when Count matches in the same cycle
      if (wr_compare) begin
        compare  <= c0_wdata;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end

      cause_ip_hw <= {ext_int[5] | cause_ti, ext_int[4:0]};

      if (wr_status) begin
        status_im  <= c0_wdata[15:8];
        status_exl <= c0_wdata[1];
        status_ie  <= c0_wdata[0];
      end
      if (wr_cause)
        cause_ip_sw <= c0_wdata[9:8];
      if (wr_epc)
        epc <= c0_wdata;

      // nested exceptions keep the original EPC/BD
      if (do_sys) begin
        cause_exc  <= 5'h08;
        status_exl <= 1'b1;
        if (!status_exl) begin
          epc      <= c0_wb_bd ? c0_wb_pc - 32'd4 : c0_wb_pc;
          cause_bd <= c0_wb_bd;
        end
      end

      if (do_eret)
        status_exl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized commits
// compared against an address-indexed register-array reference model.
module tb_cp0_regfile;

  localparam logic [31:0] EX = 32'hBFC0_0380;
  localparam bit          DIV2 = 1'b1;
  localparam int W_NONE = 0, W_SYS = 1, W_ERET = 2, W_MTC = 3, W_MFC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  c0_exception = '0;
  logic [4:0]  c0_addr = '0;
  logic [31:0] c0_wdata = '0;
  logic        c0_wb_valid = 1'b0;
  logic        c0_wb_bd = 1'b0;
  logic [31:0] c0_wb_pc = '0;
  logic [5:0]  ext_int = '0;
  logic        c0_valid;
  logic [31:0] c0_res;
  logic        flush;
  logic [31:0] flush_pc;
  logic        int_req;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_reg [32];
  logic        m_tick;

  cp0_regfile #(.EX_ENTRY(EX), .COUNT_DIV2(DIV2)) dut (
    .clk(clk), .reset(reset), .c0_exception(c0_exception), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_wb_valid(c0_wb_valid), .c0_wb_bd(c0_wb_bd),
    .c0_wb_pc(c0_wb_pc), .ext_int(ext_int), .c0_valid(c0_valid), .c0_res(c0_res),
    .flush(flush), .flush_pc(flush_pc), .int_req(int_req)
  );

  always #5 clk = ~clk;

  function automatic int winner(input logic [3:0] e, input logic v);
    if (!v)   return W_NONE;
    if (e[3]) return W_SYS;
    if (e[0]) return W_ERET;
    if (e[1]) return W_MTC;
    if (e[2]) return W_MFC;
    return W_NONE;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd9 || a == 5'd11 || a == 5'd12 || a == 5'd13 || a == 5'd14) return m_reg[a];
    return '0;
  endfunction

  function automatic logic m_int();
    return m_reg[12][0] & ~m_reg[12][1] & (|(m_reg[13][15:8] & m_reg[12][15:8]));
  endfunction

  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = '0;
    m_reg[12] = 32'h0040_0000;
    m_tick = 1'b0;
  endtask

  // Next-state of the architectural registers from the pre-edge state and current inputs
  task automatic model_edge();
    logic [31:0] n [32];
    int win;
    if (reset) begin
      model_reset();
      return;
    end
    win = winner(c0_exception, c0_wb_valid);
    n = m_reg;
    n[9] = m_reg[9] + (m_tick ? 32'd1 : 32'd0);
    if (m_reg[9] == m_reg[11]) n[13][30] = 1'b1;
    n[13][15:10] = {ext_int[5] | m_reg[13][30], ext_int[4:0]};
    case (win)
      W_SYS: begin
        n[13][6:2] = 5'd8;
        n[12][1] = 1'b1;
        if (!m_reg[12][1]) begin
          n[14] = c0_wb_pc - (c0_wb_bd ? 32'd4 : 32'd0);
          n[13][31] = c0_wb_bd;
        end
      end
      W_ERET: n[12][1] = 1'b0;
      W_MTC: begin
        case (c0_addr)
          5'd9, 5'd11, 5'd14: n[c0_addr] = c0_wdata;
          5'd12: n[12] = 32'h0040_0000 | (c0_wdata & 32'h0000_FF03);
          5'd13: n[13][9:8] = c0_wdata[9:8];
          default: ;
        endcase
        if (c0_addr == 5'd11) n[13][30] = 1'b0;
      end
      default: ;
    endcase
    m_reg = n;
    m_tick = DIV2 ? ~m_tick : 1'b1;
  endtask

  task automatic drive(input logic [3:0] e, input logic [4:0] a, input logic [31:0] w,
                       input logic v, input logic b, input logic [31:0] p);
    c0_exception = e;
    c0_addr      = a;
    c0_wdata     = w;
    c0_wb_valid  = v;
    c0_wb_bd     = b;
    c0_wb_pc     = p;
    #2;
  endtask

  task automatic idle();
    drive(4'b0000, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(4'b0100, 5'd12, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_valid !== 1'b1 || c0_res !== 32'h0040_0000) begin
      failures++;
      $display("FAIL reset_status valid=%b res=%h expected valid=1 res=00400000", c0_valid, c0_res);
    end
    checks++;
    if (flush !== 1'b0 || int_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs flush=%b int_req=%b expected 0 0", flush, int_req);
    end
    step();
    drive(4'b0100, 5'd5, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_valid !== 1'b1 || c0_res !== 32'd0) begin
      failures++;
      $display("FAIL unimpl_read valid=%b res=%h expected valid=1 res=0", c0_valid, c0_res);
    end
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'd0) begin
      failures++;
      $display("FAIL reset_epc got=%h expected=0", c0_res);
    end
    step();
  endtask

  task automatic test_sys();
    drive(4'b1000, 5'd0, 32'd0, 1'b1, 1'b0, 32'hBFC0_1000);
    checks++;
    if (flush !== 1'b1 || flush_pc !== EX) begin
      failures++;
      $display("FAIL sys_flush flush=%b pc=%h expected 1 %h", flush, flush_pc, EX);
    end
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'hBFC0_1000) begin
      failures++;
      $display("FAIL sys_epc got=%h expected=bfc01000", c0_res);
    end
    step();
    drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[6:2] !== 5'd8 || c0_res[31] !== 1'b0) begin
      failures++;
      $display("FAIL sys_cause exc=%h bd=%b expected exc=08 bd=0", c0_res[6:2], c0_res[31]);
    end
    step();
    drive(4'b0100, 5'd12, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[1] !== 1'b1) begin
      failures++;
      $display("FAIL sys_exl got=%b expected=1", c0_res[1]);
    end
    step();
    drive(4'b1000, 5'd0, 32'd0, 1'b1, 1'b1, 32'h0000_2000);
    checks++;
    if (flush !== 1'b1 || flush_pc !== EX) begin
      failures++;
      $display("FAIL nested_flush flush=%b pc=%h expected 1 %h", flush, flush_pc, EX);
    end
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'hBFC0_1000) begin
      failures++;
      $display("FAIL nested_epc got=%h expected=bfc01000", c0_res);
    end
    step();
    drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[31] !== 1'b0) begin
      failures++;
      $display("FAIL nested_bd got=%b expected=0", c0_res[31]);
    end
    step();
  endtask

  task automatic test_eret();
    drive(4'b0010, 5'd12, 32'd0, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b1000, 5'd0, 32'd0, 1'b1, 1'b1, 32'h0000_2004);
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'h0000_2000) begin
      failures++;
      $display("FAIL bd_epc got=%h expected=00002000", c0_res);
    end
    step();
    drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[31] !== 1'b1) begin
      failures++;
      $display("FAIL bd_flag got=%b expected=1", c0_res[31]);
    end
    step();
    drive(4'b0001, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h0000_2000) begin
      failures++;
      $display("FAIL eret_flush flush=%b pc=%h expected 1 00002000", flush, flush_pc);
    end
    step();
    drive(4'b0100, 5'd12, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[1] !== 1'b0) begin
      failures++;
      $display("FAIL eret_exl got=%b expected=0", c0_res[1]);
    end
    step();
  endtask

  task automatic test_count_wrap();
    int ff_cycles = 0;
    bit seen_ff = 0, seen_wrap = 0;
    drive(4'b0010, 5'd9, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(4'b0100, 5'd9, 32'd0, 1'b1, 1'b0, 32'd0);
      checks++;
      if (c0_res !== m_read(5'd9)) begin
        failures++;
        $display("FAIL count_seq cyc=%0d got=%h expected=%h", i, c0_res, m_read(5'd9));
      end
      if (c0_res === 32'hFFFF_FFFF) begin
        ff_cycles++;
        seen_ff = 1;
      end
      if (seen_ff && c0_res === 32'd0) seen_wrap = 1;
      step();
    end
    checks++;
    if (!seen_wrap || ff_cycles != 2) begin
      failures++;
      $display("FAIL count_wrap wrapped=%0d ffff_cycles=%0d expected wrapped=1 ffff_cycles=2",
               seen_wrap, ff_cycles);
    end
  endtask

  task automatic test_timer_int();
    bit hit = 0;
    drive(4'b0010, 5'd11, 32'd10, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0010, 5'd9, 32'd0, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0010, 5'd12, 32'h0000_8001, 1'b1, 1'b0, 32'd0);
    step();
    idle();
    checks++;
    if (int_req !== 1'b0) begin
      failures++;
      $display("FAIL timer_idle int_req=%b expected=0", int_req);
    end
    for (int i = 0; i < 60 && !hit; i++) begin
      drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
      checks++;
      if (c0_res !== m_read(5'd13) || int_req !== m_int()) begin
        failures++;
        $display("FAIL timer_track cyc=%0d cause=%h int_req=%b expected cause=%h int_req=%b",
                 i, c0_res, int_req, m_read(5'd13), m_int());
      end
      if (int_req === 1'b1) hit = 1;
      step();
    end
    checks++;
    if (!hit || m_reg[9] < 32'd10) begin
      failures++;
      $display("FAIL timer_fire fired=%0d count=%0d expected fired=1 count>=10", hit, m_reg[9]);
    end
    drive(4'b0010, 5'd11, 32'd100, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[30] !== 1'b0) begin
      failures++;
      $display("FAIL ti_clear got=%b expected=0", c0_res[30]);
    end
    step();
    idle();
    checks++;
    if (int_req !== 1'b0) begin
      failures++;
      $display("FAIL int_clear int_req=%b expected=0", int_req);
    end
    drive(4'b0010, 5'd11, 32'd200, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0010, 5'd9, 32'd200, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0010, 5'd11, 32'd500, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'b0100, 5'd13, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res[30] !== 1'b0) begin
      failures++;
      $display("FAIL ti_clear_wins got=%b expected=0", c0_res[30]);
    end
    step();
  endtask

  task automatic test_gating();
    drive(4'b1010, 5'd11, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_3000);
    checks++;
    if (flush !== 1'b0 || c0_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_outputs flush=%b valid=%b expected 0 0", flush, c0_valid);
    end
    step();
    drive(4'b0100, 5'd11, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'd500) begin
      failures++;
      $display("FAIL gate_compare got=%h expected=000001f4", c0_res);
    end
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'h0000_2000) begin
      failures++;
      $display("FAIL gate_epc got=%h expected=00002000", c0_res);
    end
    step();
    drive(4'b1010, 5'd11, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_3000);
    checks++;
    if (flush !== 1'b1 || flush_pc !== EX) begin
      failures++;
      $display("FAIL prio_flush flush=%b pc=%h expected 1 %h", flush, flush_pc, EX);
    end
    step();
    drive(4'b0100, 5'd11, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'd500) begin
      failures++;
      $display("FAIL prio_compare got=%h expected=000001f4", c0_res);
    end
    step();
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'h0000_3000) begin
      failures++;
      $display("FAIL prio_epc got=%h expected=00003000", c0_res);
    end
    step();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(4'b1000, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0000_4000);
    step();
    reset = 1'b0;
    drive(4'b0100, 5'd14, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'd0) begin
      failures++;
      $display("FAIL rst_epc got=%h expected=0", c0_res);
    end
    step();
    drive(4'b0100, 5'd12, 32'd0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (c0_res !== 32'h0040_0000) begin
      failures++;
      $display("FAIL rst_status got=%h expected=00400000", c0_res);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      logic [3:0] e;
      int w;
      reset = ($urandom_range(0, 99) == 0);
      ext_int = 6'($urandom);
      case ($urandom_range(0, 5))
        0: a = 5'd9;
        1: a = 5'd11;
        2: a = 5'd12;
        3: a = 5'd13;
        4: a = 5'd14;
        default: a = 5'($urandom);
      endcase
      e = $urandom_range(0, 1) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      drive(e, a, $urandom, ($urandom_range(0, 3) != 0), 1'($urandom),
            $urandom & 32'hFFFF_FFFC);
      w = winner(c0_exception, c0_wb_valid);
      checks++;
      if (c0_valid !== (w == W_MFC) || flush !== (w == W_SYS || w == W_ERET) ||
          int_req !== m_int()) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d valid=%b flush=%b int=%b expected %b %b %b", i,
                 c0_valid, flush, int_req, (w == W_MFC), (w == W_SYS || w == W_ERET), m_int());
      end
      if (w == W_MFC) begin
        checks++;
        if (c0_res !== m_read(a)) begin
          failures++;
          $display("FAIL rand_read cyc=%0d addr=%0d got=%h expected=%h", i, a, c0_res, m_read(a));
        end
      end
      if (w == W_SYS || w == W_ERET) begin
        checks++;
        if (flush_pc !== ((w == W_SYS) ? EX : m_reg[14])) begin
          failures++;
          $display("FAIL rand_pc cyc=%0d got=%h expected=%h", i, flush_pc,
                   (w == W_SYS) ? EX : m_reg[14]);
        end
      end
      step();
    end
    reset = 1'b0;
    ext_int = '0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_sys();
    test_eret();
    test_count_wrap();
    test_timer_int();
    test_gating();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
